// File: rtl/trap_commit_unit_pkg.sv
// Shared trap/return types: the writeback exception record, the commit FSM states,
// the mstatus update selector and the CSR addresses the commit unit writes.
package ExceptStruct;

    localparam int EXC_XLEN = 64;

    typedef struct packed {
        logic                except;
        logic [EXC_XLEN-1:0] epc;
        logic [EXC_XLEN-1:0] ecause;
        logic [EXC_XLEN-1:0] etval;
    } ExceptPack;

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_TVAL,
        W_STATUS,
        R_STATUS,
        REDIR
    } trap_state_e;

    typedef enum logic [1:0] {
        OP_TRAP_M,
        OP_TRAP_S,
        OP_MRET,
        OP_SRET
    } status_op_e;

    localparam logic [1:0] PRIV_U   = 2'b00;
    localparam logic [1:0] PRIV_S   = 2'b01;
    localparam logic [1:0] PRIV_M   = 2'b11;

    localparam logic [1:0] RET_SRET = 2'b01;
    localparam logic [1:0] RET_MRET = 2'b10;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

endpackage

// File: rtl/trap_status_calc.sv
// Combinational mstatus rewrite for trap entry (to M or S) and for mret/sret.
module trap_status_calc
    import ExceptStruct::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] mstatus,
    input  status_op_e      op,
    input  logic [1:0]      prev_priv,
    output logic [XLEN-1:0] status_next
);

    always_comb begin
        // NOTE: every comb output gets a default before the case so no path can infer a latch.
        status_next = mstatus;
        unique case (op)
            OP_TRAP_M: begin
                status_next[7]     = mstatus[3];
                status_next[3]     = 1'b0;
                status_next[12:11] = prev_priv;
            end
            OP_TRAP_S: begin
                status_next[5] = mstatus[1];
                status_next[1] = 1'b0;
                status_next[8] = prev_priv[0];
            end
            OP_MRET: begin
                status_next[3]     = mstatus[7];
                status_next[7]     = 1'b1;
                status_next[12:11] = 2'b00;
            end
            OP_SRET: begin
                status_next[1] = mstatus[5];
                status_next[5] = 1'b1;
                status_next[8] = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/trap_commit_unit.sv
// Commit-stage trap/return sequencer: serialises the CSR writes of a trap or xRET
// one per cycle, then redirects fetch and updates the privilege level.
module trap_commit_unit
    import ExceptStruct::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  ExceptPack       except_wb,
    input  logic            valid_wb,
    input  logic [1:0]      ret_wb,
    input  logic [1:0]      priv,
    input  logic [XLEN-1:0] medeleg,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    output logic            csr_we,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            busy,
    output logic            priv_we,
    output logic [1:0]      priv_next
);

    trap_state_e     state;
    logic [XLEN-1:0] epc_q, ecause_q, etval_q;
    logic [1:0]      priv_q, old_pp_q;
    logic            is_trap_q, to_s_q, is_mret_q;

    logic            take_trap, take_ret, deleg_s;
    status_op_e      status_op;
    logic [XLEN-1:0] status_next;
    logic [XLEN-1:0] tvec;

    assign take_trap = valid_wb && except_wb.except;
    assign take_ret  = valid_wb && !except_wb.except && (ret_wb == RET_SRET || ret_wb == RET_MRET);
    // Interrupt causes (top bit set) and traps taken in M never delegate.
    assign deleg_s   = (priv != PRIV_M) && !except_wb.ecause[XLEN-1]
                       && medeleg[except_wb.ecause[5:0]];

    assign status_op = is_trap_q ? (to_s_q ? OP_TRAP_S : OP_TRAP_M)
                                 : (is_mret_q ? OP_MRET : OP_SRET);
    assign tvec      = to_s_q ? stvec : mtvec;

    trap_status_calc #(.XLEN(XLEN)) u_status_calc (
        .mstatus     (mstatus),
        .op          (status_op),
        .prev_priv   (priv_q),
        .status_next (status_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            epc_q     <= '0;
            ecause_q  <= '0;
            etval_q   <= '0;
            priv_q    <= '0;
            old_pp_q  <= '0;
            is_trap_q <= 1'b0;
            to_s_q    <= 1'b0;
            is_mret_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_trap) begin
                        epc_q     <= except_wb.epc[XLEN-1:0];
                        ecause_q  <= except_wb.ecause[XLEN-1:0];
                        etval_q   <= except_wb.etval[XLEN-1:0];
                        priv_q    <= priv;
                        is_trap_q <= 1'b1;
                        to_s_q    <= deleg_s;
                        state     <= W_EPC;
                    end else if (take_ret) begin
                        priv_q    <= priv;
                        is_trap_q <= 1'b0;
                        is_mret_q <= (ret_wb == RET_MRET);
                        state     <= R_STATUS;
                    end
                end
                W_EPC:    state <= W_CAUSE;
                W_CAUSE:  state <= W_TVAL;
                W_TVAL:   state <= W_STATUS;
                W_STATUS: state <= REDIR;
                R_STATUS: begin
                    // Capture the previous-privilege field before the status write lands.
                    old_pp_q <= is_mret_q ? mstatus[12:11] : {1'b0, mstatus[8]};
                    state    <= REDIR;
                end
                REDIR:    state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_comb begin
        csr_we         = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        priv_we        = 1'b0;
        priv_next      = '0;
        case (state)
            W_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = to_s_q ? CSR_SEPC : CSR_MEPC;
                csr_wdata = epc_q;
            end
            W_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = to_s_q ? CSR_SCAUSE : CSR_MCAUSE;
                csr_wdata = ecause_q;
            end
            W_TVAL: begin
                csr_we    = 1'b1;
                csr_addr  = to_s_q ? CSR_STVAL : CSR_MTVAL;
                csr_wdata = etval_q;
            end
            W_STATUS, R_STATUS: begin
                csr_we    = 1'b1;
                csr_addr  = (status_op == OP_TRAP_S || status_op == OP_SRET) ? CSR_SSTATUS
                                                                             : CSR_MSTATUS;
                csr_wdata = status_next;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                priv_we        = 1'b1;
                if (is_trap_q) begin
                    redirect_pc = tvec & ~XLEN'(3);
                    priv_next   = to_s_q ? PRIV_S : PRIV_M;
                end else begin
                    redirect_pc = is_mret_q ? mepc : sepc;
                    priv_next   = old_pp_q;
                end
            end
            default: ;
        endcase
    end

    assign busy  = (state != IDLE);
    assign flush = busy;

endmodule

// File: doc/trap_commit_unit.md
TRAP_COMMIT_UNIT -- requirements
Module: trap_commit_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the data width of the CSR and PC datapaths.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port except_wb, input, ExceptStruct::ExceptPack (except, epc, ecause, etval): the exception record at writeback.
REQ-005 Port valid_wb, input, 1 bit: the writeback instruction is valid and retiring.
REQ-006 Port ret_wb, input, 2 bits: return request; 00 none, 01 sret, 10 mret, 11 treated as none.
REQ-007 Port priv, input, 2 bits: current privilege level; 00 U, 01 S, 11 M.
REQ-008 Ports medeleg, mstatus, mtvec, stvec, mepc, sepc SHALL each be XLEN-bit inputs giving the current CSR values.
REQ-009 Ports csr_we (1 bit), csr_addr (12 bits) and csr_wdata (XLEN bits) SHALL be outputs forming a single CSR write port.
REQ-010 Ports redirect_valid (1 bit) and redirect_pc (XLEN bits) SHALL be outputs forming the PC redirect to fetch.
REQ-011 Port flush, output, 1 bit: kills all younger pipeline stages.
REQ-012 Port busy, output, 1 bit: stalls the pipeline.
REQ-013 Ports priv_we (1 bit) and priv_next (2 bits) SHALL be outputs forming the privilege update.

Function
REQ-014 FSM states SHALL be IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS and REDIR.
REQ-015 In IDLE with valid_wb=1 and except_wb.except=1, the block SHALL latch except_wb, priv and the delegation decision, then go to W_EPC.
REQ-016 In IDLE with valid_wb=1, except=0 and ret_wb of 01 or 10, the block SHALL latch the return type and priv, then go to R_STATUS.
REQ-017 When except and ret_wb are both set in the same cycle, the exception SHALL win and the return SHALL be dropped.
REQ-018 While not in IDLE, all writeback inputs SHALL be ignored; with valid_wb=0 nothing SHALL be accepted.
REQ-019 Delegation to S SHALL occur only if the latched priv is not 11, ecause[63]=0 and medeleg[ecause[5:0]]=1; otherwise the target SHALL be M.
REQ-020 Trap sequence, one write per cycle with csr_we=1:
- W_EPC: xepc <- epc.
- W_CAUSE: xcause <- ecause.
- W_TVAL: xtval <- etval.
- W_STATUS: status update per REQ-022.
- REDIR: next state.
REQ-021 CSR addresses: sepc 0x141, scause 0x142, stval 0x143, sstatus 0x100; mepc 0x341, mcause 0x342, mtval 0x343, mstatus 0x300.
REQ-022 Trap status update, computed from the live mstatus sampled in W_STATUS:
- M target: MPIE[7] <- MIE[3]; MIE <- 0; MPP[12:11] <- latched priv.
- S target: SPIE[5] <- SIE[1]; SIE <- 0; SPP[8] <- latched priv[0].
- All other bits unchanged.
REQ-023 Return, one mstatus write in R_STATUS, then REDIR:
- mret: MIE <- MPIE; MPIE <- 1; MPP <- 00.
- sret: SIE <- SPIE; SPIE <- 1; SPP <- 0.
REQ-024 In REDIR the block SHALL pulse redirect_valid and priv_we for one cycle, then return to IDLE.
- Trap: redirect_pc = tvec & ~3 (direct mode only); priv_next = target level.
- mret: redirect_pc = mepc; priv_next = old MPP.
- sret: redirect_pc = sepc; priv_next = {0, old SPP}.
REQ-025 busy and flush SHALL be high in every non-IDLE state and low in IDLE.
REQ-026 Latency: acceptance in cycle N SHALL give trap redirect in cycle N+5 and return redirect in cycle N+2.
REQ-027 Outside write states, csr_we SHALL be 0 and csr_addr/csr_wdata SHALL be 0.

Reset
REQ-028 While rst=0, the FSM SHALL be IDLE, all outputs 0 and all latched fields 0, asynchronously.
REQ-029 Reset mid-sequence SHALL abandon the sequence, with no further CSR write or redirect.

Structure
REQ-030 The ExceptPack typedef, the FSM state enum and the CSR address constants SHALL live in the shared ExceptStruct package.
REQ-031 The mstatus update logic SHALL be one combinational sub-module, trap_status_calc.

Verification
REQ-032 M-mode illegal instruction: priv=11, ecause=2, epc=0x80000010, etval=0x0, mtvec=0x80000101, mstatus=0x8.
- Writes: 0x341=0x80000010, 0x342=2, 0x343=0, 0x300=0x1880.
- Redirect: 0x80000100 at N+5; priv_next=11.
REQ-033 Delegated U ecall: priv=00, ecause=8, medeleg=0x100, stvec=0x2000, mstatus=0x2.
- Writes: scause=8; sstatus bit5=1, bit1=0, bit8=0.
- Redirect: 0x2000; priv_next=01.
REQ-034 mret with mstatus=0x1880, mepc=0x1234:
- Writes: mstatus=0x88.
- Redirect: 0x1234 at N+2; priv_next=11.
REQ-035 Except and mret in the same cycle: the trap sequence only, with no return writes.
REQ-036 rst asserted in W_CAUSE: all outputs go to 0 immediately, no redirect follows, and a new trap after reset release completes normally.
